// File: rtl/tlul_host_arb_pkg.sv
// Shared definitions for the TL-UL host arbiter: FSM state encoding and the
// grant-index width helper.
package tlul_host_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  // Width of a host index; never below one bit.
  function automatic int gnt_idx_w(input int num_hosts);
    return (num_hosts > 1) ? $clog2(num_hosts) : 1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Bus-wide TL-UL packages: top-level bus widths (top_pkg) and the TL-UL
// channel structs and opcodes (tlul_pkg) shared by all TL-UL blocks.
package top_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

endpackage

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                        a_valid;
    tl_a_op_e                    a_opcode;
    logic [2:0]                  a_param;
    logic [top_pkg::TL_SZW-1:0]  a_size;
    logic [top_pkg::TL_AIW-1:0]  a_source;
    logic [top_pkg::TL_AW-1:0]   a_address;
    logic [top_pkg::TL_DBW-1:0]  a_mask;
    logic [top_pkg::TL_DW-1:0]   a_data;
    logic                        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                        d_valid;
    tl_d_op_e                    d_opcode;
    logic [2:0]                  d_param;
    logic [top_pkg::TL_SZW-1:0]  d_size;
    logic [top_pkg::TL_AIW-1:0]  d_source;
    logic [top_pkg::TL_DIW-1:0]  d_sink;
    logic [top_pkg::TL_DW-1:0]   d_data;
    logic                        d_error;
    logic                        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_pick.sv
// Round-robin picker: returns the first requesting index at or above ptr,
// wrapping modulo NumHosts. Purely combinational.
module tlul_rr_pick #(
  parameter int NumHosts = 4,
  parameter int IdxW     = 2
) (
  input  logic [NumHosts-1:0] req,
  input  logic [IdxW-1:0]     ptr,
  output logic [IdxW-1:0]     idx,
  output logic                vld
);

  logic [IdxW-1:0] cand;

  // Rotating priority search starting at ptr; the first hit wins.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 0; i < NumHosts; i++) begin
      cand = IdxW'((int'(ptr) + i) % NumHosts);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// TL-UL host arbiter: shares one device port between NumHosts hosts with
// round-robin arbitration and a single transaction in flight. The grant is
// held from A-channel accept until the matching D response is consumed.
// Optional response timeout with synthetic error response: TLUL_ARB_TIMEOUT_EN.
// A device response that arrives after a timeout is sunk in IDLE/ADDR; one
// arriving during a later RESP is misattributed to that later owner.
module tlul_host_arb
  import tlul_pkg::*;
  import tlul_host_arb_pkg::*;
#(
  parameter int NumHosts      = 4,
  parameter int TimeoutCycles = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tl_h2d_t             tl_h_i [NumHosts],
  output tl_d2h_t             tl_h_o [NumHosts],
  output tl_h2d_t             tl_d_o,
  input  tl_d2h_t             tl_d_i,
  output logic [NumHosts-1:0] grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int GntIdxW = gnt_idx_w(NumHosts);

  arb_state_e          state;
  logic [GntIdxW-1:0]  ptr;
  logic [GntIdxW-1:0]  gnt;
  logic [GntIdxW-1:0]  pick_idx;
  logic [GntIdxW-1:0]  ptr_next;
  logic                pick_vld;
  logic [NumHosts-1:0] req;
  logic                a_fire;
  logic                d_fire;

  // Collect A-channel requests for the picker.
  always_comb begin
    req = '0;
    for (int i = 0; i < NumHosts; i++) begin
      req[i] = tl_h_i[i].a_valid;
    end
  end

  tlul_rr_pick #(
    .NumHosts (NumHosts),
    .IdxW     (GntIdxW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign a_fire   = (state == ADDR) && tl_h_i[gnt].a_valid && tl_d_i.a_ready;
  assign d_fire   = (state == RESP) && tl_d_i.d_valid && tl_h_i[gnt].d_ready;
  assign ptr_next = (gnt == GntIdxW'(NumHosts - 1)) ? '0 : gnt + 1'b1;
  assign busy_o   = (state != IDLE);

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0]            cnt;
  logic                       to_hit;
  logic                       timeout_q;
  logic [top_pkg::TL_AIW-1:0] cap_source;
  logic [top_pkg::TL_SZW-1:0] cap_size;

  // Last idle RESP cycle before the limit; d_valid present holds the count.
  assign to_hit    = (state == RESP) && !tl_d_i.d_valid &&
                     (cnt == CntW'(TimeoutCycles - 1));
  assign timeout_o = timeout_q;

  // Response timer: cleared on RESP entry, counts RESP cycles without d_valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (a_fire) begin
        cnt <= '0;
      end else if ((state == RESP) && !tl_d_i.d_valid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Request id/size kept for the synthetic error response.
  always_ff @(posedge clk_i) begin
    if (a_fire) begin
      cap_source <= tl_h_i[gnt].a_source;
      cap_size   <= tl_h_i[gnt].a_size;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TimeoutCycles > 0);
  assign timeout_o          = 1'b0;
`endif

  // Arbitration FSM: owner selection, handshake tracking, pointer advance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick_idx;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (a_fire) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (d_fire) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
`ifdef TLUL_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state <= ERR;
          end
`endif
        end
`ifdef TLUL_ARB_TIMEOUT_EN
        ERR: begin
          if (tl_h_i[gnt].d_ready) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Channel steering: only the owner sees the device; D traffic outside RESP is sunk.
  always_comb begin
    tl_d_o         = '0;
    tl_d_o.d_ready = 1'b1;
    grant_o        = '0;
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i] = '0;
    end
    case (state)
      ADDR: begin
        tl_d_o                = tl_h_i[gnt];
        tl_d_o.d_ready        = 1'b1;
        tl_h_o[gnt].a_ready   = tl_d_i.a_ready;
      end
      RESP: begin
        tl_d_o.d_ready        = tl_h_i[gnt].d_ready;
        tl_h_o[gnt]           = tl_d_i;
        tl_h_o[gnt].a_ready   = 1'b0;
      end
`ifdef TLUL_ARB_TIMEOUT_EN
      ERR: begin
        tl_h_o[gnt].d_valid   = 1'b1;
        tl_h_o[gnt].d_opcode  = AccessAckData;
        tl_h_o[gnt].d_error   = 1'b1;
        tl_h_o[gnt].d_source  = cap_source;
        tl_h_o[gnt].d_size    = cap_size;
      end
`endif
      default: ;
    endcase
    if (state != IDLE) begin
      grant_o[gnt] = 1'b1;
    end
  end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed testbench for tlul_host_arb (4 hosts, TimeoutCycles = 8).
// The timeout scenario is compiled in when TLUL_ARB_TIMEOUT_EN is defined.
module tb_tlul_host_arb;
  import tlul_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  tl_h2d_t      tl_h_i [N];
  tl_d2h_t      tl_h_o [N];
  tl_h2d_t      tl_d_o;
  tl_d2h_t      tl_d_i;
  logic [N-1:0] grant_o;
  logic         busy_o;
  logic         timeout_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int dev_req   = 0;

  always #5 clk = ~clk;

  tlul_host_arb #(
    .NumHosts      (N),
    .TimeoutCycles (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .tl_h_i    (tl_h_i),
    .tl_h_o    (tl_h_o),
    .tl_d_o    (tl_d_o),
    .tl_d_i    (tl_d_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  // Device-side accepted A requests
  always @(posedge clk) begin
    if (rst_ni && tl_d_o.a_valid && tl_d_i.a_ready) dev_req++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    for (int i = 0; i < N; i++) begin
      tl_h_i[i]         = '0;
      tl_h_i[i].d_ready = 1'b1;
    end
    tl_d_i         = '0;
    tl_d_i.a_ready = 1'b1;
  endtask

  task automatic host_req(input int h, input logic [7:0] src);
    tl_h_i[h].a_valid   = 1'b1;
    tl_h_i[h].a_opcode  = PutFullData;
    tl_h_i[h].a_size    = 2'd2;
    tl_h_i[h].a_source  = src;
    tl_h_i[h].a_address = 32'h10 + 32'h100 * h;
    tl_h_i[h].a_mask    = 4'hF;
    tl_h_i[h].a_data    = 32'hCAFE_0000 + h;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    quiet();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic wait_grant(input int h);
    for (int w = 0; w < 10 && grant_o[h] == 1'b0; w++) tick();
  endtask

  // Complete one transaction for host h (stimulus only).
  task automatic run_txn(input int h);
    host_req(h, 8'(8'h40 + h));
    tl_d_i.a_ready = 1'b1;
    wait_grant(h);
    tick();
    tl_h_i[h].a_valid = 1'b0;
    tl_d_i.d_valid    = 1'b1;
    tl_d_i.d_opcode   = AccessAck;
    tl_d_i.d_source   = 8'(8'h40 + h);
    tick();
    tl_d_i.d_valid    = 1'b0;
  endtask

  task automatic test_reset();
    logic any_h;
    rst_ni = 1'b0;
    quiet();
    host_req(0, 8'h01);
    tick();
    tick();
    any_h = 1'b0;
    for (int i = 0; i < N; i++) any_h |= tl_h_o[i].a_ready | tl_h_o[i].d_valid;
    total_cnt++;
    if ({grant_o, busy_o, timeout_o} !== 6'b0)
      $display("FAIL reset_ctrl: got grant=%b busy=%b timeout=%b, need all 0", grant_o, busy_o, timeout_o);
    else pass_cnt++;
    total_cnt++;
    if ({tl_d_o.a_valid, tl_d_o.d_ready} !== 2'b01)
      $display("FAIL reset_dev: got a_valid=%b d_ready=%b, need 0/1", tl_d_o.a_valid, tl_d_o.d_ready);
    else pass_cnt++;
    total_cnt++;
    if (any_h !== 1'b0) $display("FAIL reset_host: host handshake got %b need 0", any_h);
    else pass_cnt++;
    quiet();
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    int d0;
    logic any_other;
    do_reset();
    host_req(0, 8'h5A);
    settle();
    total_cnt++;
    if ({grant_o, tl_h_o[0].a_ready} !== 5'b0)
      $display("FAIL single_idle: got grant=%b a_ready=%b, need 0", grant_o, tl_h_o[0].a_ready);
    else pass_cnt++;
    d0 = dev_req;
    tick();
    total_cnt++;
    if (grant_o !== 4'b0001) $display("FAIL single_grant: got %b need 0001", grant_o);
    else pass_cnt++;
    total_cnt++;
    if (!(tl_d_o.a_valid === 1'b1 && tl_d_o.a_address === 32'h10 &&
          tl_d_o.a_source === 8'h5A && tl_h_o[0].a_ready === 1'b1))
      $display("FAIL single_addr: got a_valid=%b addr=%h src=%h a_ready=%b, need 1/10/5a/1",
               tl_d_o.a_valid, tl_d_o.a_address, tl_d_o.a_source, tl_h_o[0].a_ready);
    else pass_cnt++;
    tick();
    tl_h_i[0].a_valid = 1'b0;
    settle();
    total_cnt++;
    if ({tl_d_o.a_valid, tl_h_o[0].d_valid, busy_o} !== 3'b001)
      $display("FAIL single_resp_wait: got a_valid=%b d_valid=%b busy=%b, need 0/0/1",
               tl_d_o.a_valid, tl_h_o[0].d_valid, busy_o);
    else pass_cnt++;
    tick();
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAck;
    tl_d_i.d_source = 8'h5A;
    tl_d_i.d_size   = 2'd2;
    settle();
    any_other = 1'b0;
    for (int i = 1; i < N; i++) any_other |= tl_h_o[i].d_valid;
    total_cnt++;
    if (!(tl_h_o[0].d_valid === 1'b1 && tl_h_o[0].d_source === 8'h5A &&
          tl_h_o[0].d_opcode === AccessAck && tl_d_o.d_ready === 1'b1 && any_other === 1'b0))
      $display("FAIL single_ack: got d_valid=%b src=%h op=%0d d_ready=%b others=%b, need 1/5a/0/1/0",
               tl_h_o[0].d_valid, tl_h_o[0].d_source, tl_h_o[0].d_opcode, tl_d_o.d_ready, any_other);
    else pass_cnt++;
    tick();
    tl_d_i.d_valid = 1'b0;
    settle();
    total_cnt++;
    if ({busy_o, grant_o} !== 5'b0 || (dev_req - d0) != 1)
      $display("FAIL single_done: got busy=%b grant=%b reqs=%0d, need 0/0000/1", busy_o, grant_o, dev_req - d0);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int h = 0; h < N; h++) host_req(h, 8'(8'h80 + h));
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAck;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10 && grant_o == 4'b0; w++) tick();
      exp = 4'b0001 << (k % 4);
      total_cnt++;
      if (grant_o !== exp) $display("FAIL rr_order_%0d: got %b need %b", k, grant_o, exp);
      else pass_cnt++;
      for (int w = 0; w < 10 && grant_o != 4'b0; w++) tick();
    end
  endtask

  task automatic test_a_stall();
    int d0;
    do_reset();
    tl_d_i.a_ready = 1'b0;
    host_req(1, 8'h21);
    wait_grant(1);
    d0 = dev_req;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if ({tl_d_o.a_valid, tl_h_o[1].a_ready, grant_o, busy_o} !== 7'b1_0_0010_1)
        $display("FAIL stall_cycle_%0d: got a_valid=%b a_ready=%b grant=%b busy=%b, need 1/0/0010/1",
                 c, tl_d_o.a_valid, tl_h_o[1].a_ready, grant_o, busy_o);
      else pass_cnt++;
      tick();
    end
    tl_d_i.a_ready = 1'b1;
    settle();
    total_cnt++;
    if (tl_h_o[1].a_ready !== 1'b1 || tl_d_o.a_source !== 8'h21)
      $display("FAIL stall_release: got a_ready=%b src=%h need 1/21", tl_h_o[1].a_ready, tl_d_o.a_source);
    else pass_cnt++;
    tick();
    tl_h_i[1].a_valid = 1'b0;
    settle();
    total_cnt++;
    if (tl_d_o.a_valid !== 1'b0 || (dev_req - d0) != 1)
      $display("FAIL stall_accept: got a_valid=%b reqs=%0d need 0/1", tl_d_o.a_valid, dev_req - d0);
    else pass_cnt++;
  endtask

  task automatic test_spurious_d();
    logic any_d;
    do_reset();
    run_txn(1);
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_source = 8'h77;
    for (int c = 0; c < 2; c++) begin
      settle();
      any_d = 1'b0;
      for (int i = 0; i < N; i++) any_d |= tl_h_o[i].d_valid;
      total_cnt++;
      if ({tl_d_o.d_ready, any_d, busy_o} !== 3'b100)
        $display("FAIL spurious_%0d: got d_ready=%b host_d_valid=%b busy=%b need 1/0/0",
                 c, tl_d_o.d_ready, any_d, busy_o);
      else pass_cnt++;
      tick();
    end
    tl_d_i.d_valid = 1'b0;
    host_req(0, 8'h30);
    host_req(3, 8'h33);
    tick();
    total_cnt++;
    if (grant_o !== 4'b1000) $display("FAIL spurious_ptr: got grant %b need 1000", grant_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_txn(2);
    host_req(1, 8'h11);
    wait_grant(1);
    tick();
    tl_h_i[1].a_valid = 1'b0;
    settle();
    total_cnt++;
    if ({busy_o, grant_o} !== 5'b1_0010) $display("FAIL midrst_pre: got busy=%b grant=%b need 1/0010", busy_o, grant_o);
    else pass_cnt++;
    rst_ni = 1'b0;
    tick();
    rst_ni          = 1'b1;
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_source = 8'h11;
    settle();
    total_cnt++;
    if ({busy_o, grant_o, tl_h_o[1].d_valid, tl_d_o.d_ready} !== 7'b0_0000_0_1)
      $display("FAIL midrst_after: got busy=%b grant=%b h1_d_valid=%b d_ready=%b need 0/0000/0/1",
               busy_o, grant_o, tl_h_o[1].d_valid, tl_d_o.d_ready);
    else pass_cnt++;
    tick();
    tl_d_i.d_valid = 1'b0;
    host_req(2, 8'h22);
    host_req(3, 8'h23);
    tick();
    total_cnt++;
    if (grant_o !== 4'b0100) $display("FAIL midrst_ptr: got grant %b need 0100", grant_o);
    else pass_cnt++;
  endtask

`ifdef TLUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    host_req(0, 8'h33);
    tl_h_i[0].a_size = 2'd1;
    wait_grant(0);
    tick();
    tl_h_i[0].a_valid = 1'b0;
    n = 0;
    while (timeout_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n != 8) $display("FAIL timeout_cycles: got %0d RESP cycles need 8", n);
    else pass_cnt++;
    total_cnt++;
    if (!(tl_h_o[0].d_valid === 1'b1 && tl_h_o[0].d_error === 1'b1 && tl_h_o[0].d_source === 8'h33 &&
          tl_h_o[0].d_size === 2'd1 && tl_h_o[0].d_opcode === AccessAckData && tl_h_o[0].d_data === 32'h0))
      $display("FAIL timeout_err: got d_valid=%b err=%b src=%h size=%0d op=%0d data=%h need 1/1/33/1/1/0",
               tl_h_o[0].d_valid, tl_h_o[0].d_error, tl_h_o[0].d_source, tl_h_o[0].d_size,
               tl_h_o[0].d_opcode, tl_h_o[0].d_data);
    else pass_cnt++;
    host_req(0, 8'h34);
    host_req(1, 8'h35);
    tick();
    total_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL timeout_pulse: got %b need 0", timeout_o);
    else pass_cnt++;
    wait_grant(1);
    total_cnt++;
    if (grant_o !== 4'b0010) $display("FAIL timeout_next: got grant %b need 0010", grant_o);
    else pass_cnt++;
  endtask
`else
  task automatic test_timeout();
    logic seen_to;
    do_reset();
    host_req(0, 8'h33);
    wait_grant(0);
    tick();
    tl_h_i[0].a_valid = 1'b0;
    seen_to = 1'b0;
    for (int c = 0; c < 20; c++) begin
      seen_to |= timeout_o | tl_h_o[0].d_valid;
      tick();
    end
    total_cnt++;
    if ({seen_to, busy_o, grant_o} !== 6'b0_1_0001)
      $display("FAIL no_timeout: got seen=%b busy=%b grant=%b need 0/1/0001", seen_to, busy_o, grant_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    quiet();
    test_reset();
    test_single();
    test_round_robin();
    test_a_stall();
    test_spurious_d();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
